// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its boot loader.
// No logic here.
// No flow control here.
package mem_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } load_state_t;

    localparam logic [31:0] MMIO_ADDR_DEF = 32'hFFFF_FFF0;
    localparam int          BYTE_LANES    = 4;

endpackage

// File: rtl/boot_loader.sv
// Assembles the boot byte stream into little-endian words and holds the CPU in reset until done.
// Latency: the word write request is issued combinationally in the cycle its fourth byte arrives.
// Backpressure: none; bytes are taken whenever load_valid_i is high in LOAD, gaps allowed.
module boot_loader
    import mem_pkg::*;
#(
    parameter int AW         = 10,
    parameter int LOAD_WORDS = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid_i,
    input  logic [7:0]    load_byte_i,
    output logic          wr_en,
    output logic [AW-1:0] wr_idx,
    output logic [31:0]   wr_word,
    output logic          load_active,
    output logic          cpu_reset_o,
    output logic          load_done_o
);

    localparam logic [1:0]  LAST_LANE = 2'(BYTE_LANES - 1);
    localparam logic [AW:0] LAST_WORD = (AW + 1)'(LOAD_WORDS - 1);

    load_state_t state, state_nxt;
    logic [1:0]  byte_cnt;
    logic [23:0] byte_buf;
    // One extra bit so a full-depth load ends without wrapping to zero.
    logic [AW:0] word_ptr;

    always_comb begin
        wr_en     = (state == LOAD) && load_valid_i && (byte_cnt == LAST_LANE);
        wr_idx    = word_ptr[AW-1:0];
        wr_word   = {load_byte_i, byte_buf};
        state_nxt = state;
        if (state == LOAD) begin
            if (LOAD_WORDS == 0) begin
                state_nxt = RUN;
            end else if (wr_en && (word_ptr == LAST_WORD)) begin
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD;
            byte_cnt <= 2'd0;
            byte_buf <= 24'd0;
            word_ptr <= '0;
        end else begin
            state <= state_nxt;
            if ((state == LOAD) && load_valid_i) begin
                case (byte_cnt)
                    2'd0:    byte_buf[7:0]   <= load_byte_i;
                    2'd1:    byte_buf[15:8]  <= load_byte_i;
                    2'd2:    byte_buf[23:16] <= load_byte_i;
                    default: byte_buf        <= byte_buf;
                endcase
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (wr_en) begin
                word_ptr <= word_ptr + 1'b1;
            end
        end
    end

    assign load_active = (state == LOAD);
    assign cpu_reset_o = (state == LOAD);
    assign load_done_o = (state == RUN);

endmodule

// File: rtl/mem_responder.sv
// CPU-side word RAM with one byte-wide MMIO output register and a boot loader front end.
// Latency: reads return one cycle after the address; writes land on the same edge.
// Backpressure: none; the CPU is held in reset instead of stalled while loading.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH      = 1024,
    parameter int          AW         = 10,
    parameter int          LOAD_WORDS = 256,
    parameter logic [31:0] MMIO_ADDR  = MMIO_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        load_valid_i,
    input  logic [7:0]  load_byte_i,
    output logic        cpu_reset_o,
    output logic        load_done_o,
    output logic [7:0]  io_o,
    output logic        io_strobe_o
);

    logic [31:0] mem [DEPTH];

    logic          ld_wr_en;
    logic [AW-1:0] ld_wr_idx;
    logic [31:0]   ld_wr_word;
    logic          load_active;

    logic [AW-1:0] idx;
    logic          in_range;
    logic          mmio_hit;
    logic          cpu_we;
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdat;
    logic          unused_addr_bits;

    boot_loader #(
        .AW         (AW),
        .LOAD_WORDS (LOAD_WORDS)
    ) u_boot_loader (
        .clk          (clk),
        .reset        (reset),
        .load_valid_i (load_valid_i),
        .load_byte_i  (load_byte_i),
        .wr_en        (ld_wr_en),
        .wr_idx       (ld_wr_idx),
        .wr_word      (ld_wr_word),
        .load_active  (load_active),
        .cpu_reset_o  (cpu_reset_o),
        .load_done_o  (load_done_o)
    );

    assign idx              = addr_i[AW+1:2];
    assign in_range         = (addr_i[31:AW+2] == '0);
    assign mmio_hit         = (addr_i == MMIO_ADDR);
    assign cpu_we           = we_i && !load_active;
    assign unused_addr_bits = ^addr_i[1:0];

    // The loader owns the write port for the whole LOAD phase.
    always_comb begin
        mem_we   = 1'b0;
        mem_widx = idx;
        mem_wdat = data_i;
        if (load_active) begin
            mem_we   = ld_wr_en;
            mem_widx = ld_wr_idx;
            mem_wdat = ld_wr_word;
        end else begin
            mem_we = cpu_we && in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdat;
        end
    end

    // Read-first: the registered read sees the array before this edge's write.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_o <= 32'd0;
        end else if (load_active) begin
            data_o <= 32'd0;
        end else if (in_range) begin
            data_o <= mem[idx];
        end else if (mmio_hit) begin
            data_o <= {24'd0, io_o};
        end else begin
            data_o <= 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io_o        <= 8'd0;
            io_strobe_o <= 1'b0;
        end else begin
            io_strobe_o <= cpu_we && mmio_hit;
            if (cpu_we && mmio_hit) begin
                io_o <= data_i[7:0];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a two-word boot image.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        load_valid_i;
    logic [7:0]  load_byte_i;
    logic        cpu_reset_o;
    logic        load_done_o;
    logic [7:0]  io_o;
    logic        io_strobe_o;

    int total = 0;
    int bad   = 0;

    mem_responder #(
        .DEPTH      (1024),
        .AW         (10),
        .LOAD_WORDS (2),
        .MMIO_ADDR  (32'hFFFF_FFF0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .load_valid_i (load_valid_i),
        .load_byte_i  (load_byte_i),
        .cpu_reset_o  (cpu_reset_o),
        .load_done_o  (load_done_o),
        .io_o         (io_o),
        .io_strobe_o  (io_strobe_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid_i = 1'b1;
        load_byte_i  = b;
        tick();
        load_valid_i = 1'b0;
    endtask

    task automatic read_word(input logic [31:0] a);
        we_i   = 1'b0;
        addr_i = a;
        tick();
    endtask

    initial begin
        reset        = 1'b1;
        we_i         = 1'b0;
        addr_i       = 32'd0;
        data_i       = 32'd0;
        load_valid_i = 1'b0;
        load_byte_i  = 8'd0;
        tick();
        tick();

        check("rst_data_o", data_o, 32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
        check("rst_load_done", {31'd0, load_done_o}, 32'd0);
        check("rst_io", {24'd0, io_o}, 32'd0);
        check("rst_strobe", {31'd0, io_strobe_o}, 32'd0);

        // Partial load of five bytes, then reset discards it.
        reset = 1'b0;
        send_byte(8'hAA);
        send_byte(8'hBB);
        tick();
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'hEE);
        check("partial_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);

        // Fresh load; a CPU write to word 0 during LOAD must be ignored.
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        we_i   = 1'b1;
        addr_i = 32'h0;
        data_i = 32'hDEAD_DEAD;
        send_byte(8'h55);
        tick();
        send_byte(8'h66);
        check("load_data_o_forced", data_o, 32'd0);
        send_byte(8'h77);
        check("pre_last_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
        check("pre_last_done", {31'd0, load_done_o}, 32'd0);
        send_byte(8'h88);
        we_i = 1'b0;
        check("post_last_cpu_reset", {31'd0, cpu_reset_o}, 32'd0);
        check("post_last_done", {31'd0, load_done_o}, 32'd1);
        check("last_load_data_o", data_o, 32'd0);

        read_word(32'h0);
        check("ram0_loaded", data_o, 32'h4433_2211);
        read_word(32'h4);
        check("ram1_loaded", data_o, 32'h8877_6655);

        // RUN write then read.
        we_i   = 1'b1;
        addr_i = 32'h8;
        data_i = 32'hDEAD_BEEF;
        tick();
        read_word(32'h8);
        check("run_write_read", data_o, 32'hDEAD_BEEF);
        // Byte-offset bits are ignored.
        read_word(32'hB);
        check("addr_low_bits", data_o, 32'hDEAD_BEEF);

        we_i   = 1'b1;
        addr_i = 32'h8;
        data_i = 32'hCAFE_F00D;
        tick();
        check("read_first_old", data_o, 32'hDEAD_BEEF);
        read_word(32'h8);
        check("read_after_rw", data_o, 32'hCAFE_F00D);

        // MMIO write, one-cycle strobe, readback.
        we_i   = 1'b1;
        addr_i = 32'hFFFF_FFF0;
        data_i = 32'h0000_01A5;
        tick();
        check("mmio_io", {24'd0, io_o}, 32'h0000_00A5);
        check("mmio_strobe_hi", {31'd0, io_strobe_o}, 32'd1);
        read_word(32'hFFFF_FFF0);
        check("mmio_strobe_lo", {31'd0, io_strobe_o}, 32'd0);
        check("mmio_readback", data_o, 32'h0000_00A5);
        read_word(32'h0);
        check("mmio_ram0_same", data_o, 32'h4433_2211);
        read_word(32'hFFFF_FFF4);
        check("near_mmio_read", data_o, 32'd0);

        // Out-of-range write aliases word 0 by index but must be dropped.
        we_i   = 1'b1;
        addr_i = 32'h0000_1000;
        data_i = 32'h5555_5555;
        tick();
        check("oor_no_strobe", {31'd0, io_strobe_o}, 32'd0);
        read_word(32'h0000_1000);
        check("oor_read_zero", data_o, 32'd0);
        read_word(32'h0);
        check("oor_ram0_same", data_o, 32'h4433_2211);

        // Boot bytes in RUN must not reach the RAM.
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h08);
        check("run_cpu_reset", {31'd0, cpu_reset_o}, 32'd0);
        read_word(32'h8);
        check("run_bytes_ram2", data_o, 32'hCAFE_F00D);
        read_word(32'h0);
        check("run_bytes_ram0", data_o, 32'h4433_2211);
        read_word(32'h4);
        check("run_bytes_ram1", data_o, 32'h8877_6655);
        check("io_held", {24'd0, io_o}, 32'h0000_00A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's single-port RAM bus. The CPU drives write-enable, address and write data, and this block returns read data.
- Contains a word RAM, one memory-mapped output register, and a boot loader.
- At power-up the boot loader fills the RAM from a byte stream and holds the CPU in reset. It then releases the CPU.
- Sits beside the cpu top level in the system wrapper.

Parameters:
- DEPTH, 1024, number of 32-bit RAM words.
- AW, 10, RAM index width; must equal log2(DEPTH).
- LOAD_WORDS, 256, number of words the boot loader writes before releasing the CPU; legal range 0..DEPTH.
- MMIO_ADDR, 32'hFFFF_FFF0, byte address of the output register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- we_i  in  1  CPU write enable
- addr_i  in  32  CPU byte address; bits [1:0] ignored
- data_i  in  32  CPU write data
- data_o  out  32  read data to CPU
- load_valid_i  in  1  boot byte valid, one byte per asserted cycle
- load_byte_i  in  8  boot byte
- cpu_reset_o  out  1  holds the CPU in reset while loading
- load_done_o  out  1  high once loading has completed
- io_o  out  8  memory-mapped output register
- io_strobe_o  out  1  one-cycle pulse on each MMIO write

Behaviour:
- Reset: one clock and synchronous, active-high reset.
  - Reset values: data_o=0, cpu_reset_o=1, load_done_o=0, io_o=0, io_strobe_o=0.
  - Loader returns to LOAD with byte count 0 and word pointer 0.
  - RAM contents are not cleared.
- Address decode:
  - Word index = addr_i[AW+1:2].
  - In range means addr_i[31:AW+2]==0.
  - MMIO hit means addr_i==MMIO_ADDR, exact match on all 32 bits.
- Reads: synchronous, latency 1. data_o is registered and reflects the address presented in the previous cycle.
  - In range: data_o = RAM word.
  - MMIO hit: data_o = {24'b0, io_o}.
  - Otherwise: data_o = 0.
- Writes (RUN state only), applied on the clock edge when we_i=1:
  - In range: RAM word <= data_i.
  - MMIO hit: io_o <= data_i[7:0] and io_strobe_o=1 for the following cycle only.
  - Out-of-range, non-MMIO writes are dropped silently.
- Read/write to the same address in the same cycle: read-first; data_o returns the old word.
- Loader FSM states: LOAD, RUN.
  - LOAD: cpu_reset_o=1. All CPU writes are ignored and data_o is forced to 0.
  - Each load_valid_i cycle stores load_byte_i into byte lane byte_cnt, little-endian: the first byte goes to bits [7:0].
  - byte_cnt wraps 3->0. When the fourth byte arrives, the assembled word is written to RAM[word_ptr] and word_ptr increments.
  - Transition: after the write of word LOAD_WORDS-1 the FSM goes to RUN on the next edge; cpu_reset_o=0 and load_done_o=1 from that cycle.
  - LOAD_WORDS=0: the FSM goes to RUN on the first edge after reset deasserts.
  - Gaps in load_valid_i are allowed; state holds.
  - RUN: load_valid_i is ignored. RUN is terminal until reset.
- Reset mid-load: partially assembled word is discarded; loading restarts at word 0, byte 0. Already-written words remain but will be overwritten.
- word_ptr width AW+1 so that LOAD_WORDS=DEPTH does not wrap.

Decomposition:
- Package mem_pkg holds:
  - the loader state enum (LOAD, RUN);
  - the default MMIO_ADDR constant;
  - the byte-lane count constant (4).
- One sub-module, boot_loader, contains the FSM, byte assembler, word pointer and cpu_reset_o/load_done_o.
  - Its outputs to mem_responder: a write request with index and word, plus the load-active flag.
- mem_responder owns the RAM array, address decode, read register and MMIO register. It muxes the loader write port against the CPU write port; the loader wins while in LOAD.

Test Plan:
- Boot load, LOAD_WORDS=2, bytes 11,22,33,44,55,66,77,88 -> RAM[0]=32'h44332211, RAM[1]=32'h88776655; cpu_reset_o falls the cycle after the 8th byte; load_done_o=1.
- RUN write/read: we_i=1, addr=32'h8, data=32'hDEADBEEF, then read addr 32'h8 -> data_o=32'hDEADBEEF one cycle after the read address. Same-cycle write and read of addr 32'h8 -> old value returned.
- MMIO: write 32'h0000_01A5 to 32'hFFFF_FFF0 -> io_o=8'hA5 with io_strobe_o high exactly one cycle; readback -> 32'h0000_00A5; RAM unchanged.
- Out of range, DEPTH=1024: write to 32'h0000_1000 -> dropped, RAM[0] unchanged; read -> 0.
- Reset mid-load: reset after 5 bytes, then 8 fresh bytes -> words 0/1 hold the fresh data; cpu_reset_o stays 1 throughout until completion.
- LOAD-phase CPU write: we_i=1 to addr 0 during LOAD -> ignored; data_o=0 during LOAD; load_valid_i in RUN -> no RAM change.
